sobel_stream_engine: RTL and testbench
======================================

// Module: sobel_stream_engine
// PURPOSE
//  Streaming, parametrised Sobel edge engine for raster-order pixel streams.
//  Owns two line buffers and the 3x3 window, zero-pads image borders and drains the last row itself.
//  Computes saturated |Gx|+|Gy| plus a threshold flag for each pixel.
//  Valid/ready handshakes on both sides; replaces the fixed 8-bit loader/gradient pair.
// PARAMETERS
//  PIX_W   8    pixel and gradient width in bits
//  IMG_W   640  pixels per row (>=2)
//  IMG_H   480  rows per frame (>=2)
//  CNT_W   10   row/column counter width (2^CNT_W >= max(IMG_W,IMG_H))
// PORTS
//  Clk         in   1      clock, all logic on rising edge
//  Reset       in   1      synchronous, active-high; clears all state
//  DataIn      in   PIX_W  input pixel, raster order
//  InValid     in   1      DataIn valid
//  InReady     out  1      engine accepts DataIn; transfer when InValid&&InReady
//  T           in   PIX_W  threshold, sampled at stage-2 compute
//  BinaryMode  in   1      1: Gradient = Dop ? all-ones : 0
//  Gradient    out  PIX_W  saturated |Gx|+|Gy| (or binary map)
//  Dop         out  1      edge flag, Gradient_raw > T (strict)
//  OutValid    out  1      output pixel valid
//  OutReady    in   1      sink accepts; transfer when OutValid&&OutReady
//  Out_Row     out  CNT_W  row of output pixel
//  Out_Column  out  CNT_W  column of output pixel
//  isEnd       out  1      with OutValid: last pixel of frame (IMG_H-1,IMG_W-1)
// BEHAVIOUR
//  Reset: OutValid=0, Gradient=0, Dop=0, Out_Row=0, Out_Column=0, isEnd=0, state=FILL, counters 0.
//  Window P0..P8 row-major, P4 = centre (r,c); any tap with row/col outside image reads 0 (mask
//   from counters, never from buffer contents -> stale line-buffer data is harmless).
//  Gx=(P2+2P5+P8)-(P0+2P3+P6); Gy=(P6+2P7+P8)-(P0+2P1+P2); signed PIX_W+3 bits, no overflow.
//  Raw = min(|Gx|+|Gy|, 2^PIX_W-1); Dop = Raw > T; Gradient = BinaryMode ? {PIX_W{Dop}} : Raw.
//  Output (r,c) triggered by acceptance of input index r*IMG_W+c+IMG_W+1 (or flush slot).
//  Pipeline: stage1 window register, stage2 result register; OutValid 2 cycles after trigger.
//  Stall = OutValid && !OutReady; stall freezes both stages, counters and buffers; outputs stable.
//  InReady = (state != FLUSH) && !Stall (combinational).
//  FSM:
//   FILL : accept first IMG_W+1 pixels, no outputs triggered; -> RUN after (IMG_W+1)th accept.
//   RUN  : each accept triggers one output; -> FLUSH when pixel (IMG_H-1,IMG_W-1) accepted.
//   FLUSH: InReady=0; inject IMG_W+1 zero slots, one per non-stalled cycle, each triggers an output;
//          -> FILL when output with isEnd handshakes; counters reset for next frame.
//  Exactly IMG_W*IMG_H outputs per frame, raster order, no duplicates/drops.
//  Column wrap: right/left column taps masked at c=IMG_W-1 / c=0; row wrap increments Out_Row.
//  Degenerate IMG_W=2 / IMG_H=2 supported (FILL spans row 0 + 1 pixel; FLUSH covers last row).
//  Next frame's pixels are not accepted until FLUSH completes (InReady=0 throughout FLUSH).
//  Reset mid-frame: next cycle OutValid=0, state FILL, partial frame discarded, no outputs emitted.
//  Line buffers: 2 x IMG_W x PIX_W, single write/read per accept; RAM or register inference allowed.
// TESTING (IMG_W=4, IMG_H=4, PIX_W=8, OutReady=1 unless stated)
//  1 All-zero frame -> 16 outputs Gradient=0, Dop=0, raster (0,0)..(3,3), isEnd only on (3,3).
//  2 Constant 100, T=0 -> corner (0,0) Gx=Gy=300 -> Gradient=255, Dop=1; (1,1) Gradient=0, Dop=0.
//  3 Cols 0-1 = 0, cols 2-3 = 255 -> (1,1),(1,2) Gradient=255; (1,0) Gradient=0; compare full model.
//  4 OutReady=0 for 5 cycles mid-frame -> OutValid/Gradient/Out_Row held, InReady=0, 16 outputs total.
//  5 BinaryMode=1, T=200, pattern 3 -> Gradient in {0,255}, equals 255 exactly where Dop=1.
//  6 Reset after 7 accepts -> next cycle OutValid=0, InReady=1; fresh frame gives correct 16 outputs.

Source files
------------

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel engine: two line buffers, a counter-masked window, and a
// two-stage pipeline producing saturated |Gx|+|Gy|, a threshold flag and the pixel position.
module sobel_stream_engine #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [PIX_W-1:0] DataIn,
    input  logic             InValid,
    output logic             InReady,
    input  logic [PIX_W-1:0] T,
    input  logic             BinaryMode,
    output logic [PIX_W-1:0] Gradient,
    output logic             Dop,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CNT_W-1:0] Out_Row,
    output logic [CNT_W-1:0] Out_Column,
    output logic             isEnd
);

    localparam int GW = PIX_W + 3;
    localparam int AW = $clog2(IMG_W);
    localparam int FW = $clog2(IMG_W + 2);
    localparam logic [CNT_W-1:0] LAST_COL    = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW    = CNT_W'(IMG_H - 1);
    localparam logic [AW-1:0]    LB_LAST     = AW'(IMG_W - 1);
    localparam logic [FW-1:0]    FLUSH_SLOTS = FW'(IMG_W + 1);
    localparam logic [GW:0]      MAG_MAX     = (GW + 1)'(2 ** PIX_W - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    typedef logic [PIX_W-1:0] pix_t;

    function automatic logic signed [GW-1:0] ext(input pix_t p);
        return signed'({3'b000, p});
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
    logic [CNT_W-1:0] trig_row_q, trig_row_d, trig_col_q, trig_col_d;
    logic [AW-1:0]    lb_col_q, lb_col_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    pix_t             left_col_q [3], left_col_d [3];
    pix_t             mid_col_q [3], mid_col_d [3];
    logic             s1_valid_q, s1_valid_d;
    pix_t             s1_win_q [9], s1_win_d [9];
    logic [CNT_W-1:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
    logic             s1_end_q, s1_end_d;
    logic             out_valid_q, out_valid_d;
    pix_t             grad_q, grad_d;
    logic             dop_q, dop_d;
    logic [CNT_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic             out_end_q, out_end_d;

    pix_t lb0_mem [IMG_W];
    pix_t lb1_mem [IMG_W];
    pix_t lb0_rd, lb1_rd, pix_in;
    pix_t raw_win [9], win [9];
    logic stall, in_ready, accept, flush_slot, slot, trig;

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        abs_gx, abs_gy;
    logic [GW:0]          mag;
    pix_t                 raw;
    logic                 dop_raw;

    assign lb0_rd = lb0_mem[lb_col_q];
    assign lb1_rd = lb1_mem[lb_col_q];

    // A slot is one step of the window: a real accept, or a zero injected while draining.
    always_comb begin
        stall      = out_valid_q && !OutReady;
        in_ready   = (state_q != FLUSH) && !stall;
        accept     = InValid && in_ready;
        flush_slot = (state_q == FLUSH) && !stall && (flush_cnt_q != FLUSH_SLOTS);
        slot       = accept || flush_slot;
        trig       = flush_slot || (accept && (state_q == RUN));
        pix_in     = accept ? DataIn : '0;
    end

    // Out-of-image taps are zeroed from the centre position only, so stale
    // line-buffer or window contents never reach the arithmetic.
    always_comb begin
        raw_win = '{left_col_q[0], mid_col_q[0], lb1_rd,
                    left_col_q[1], mid_col_q[1], lb0_rd,
                    left_col_q[2], mid_col_q[2], pix_in};
        for (int i = 0; i < 9; i++) begin
            if ((i < 3 && trig_row_q == '0) || (i >= 6 && trig_row_q == LAST_ROW) ||
                (i % 3 == 0 && trig_col_q == '0) || (i % 3 == 2 && trig_col_q == LAST_COL))
                win[i] = '0;
            else
                win[i] = raw_win[i];
        end
    end

    always_comb begin
        gx = (ext(s1_win_q[2]) + (ext(s1_win_q[5]) <<< 1) + ext(s1_win_q[8]))
           - (ext(s1_win_q[0]) + (ext(s1_win_q[3]) <<< 1) + ext(s1_win_q[6]));
        gy = (ext(s1_win_q[6]) + (ext(s1_win_q[7]) <<< 1) + ext(s1_win_q[8]))
           - (ext(s1_win_q[0]) + (ext(s1_win_q[1]) <<< 1) + ext(s1_win_q[2]));
        abs_gx  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag     = {1'b0, abs_gx} + {1'b0, abs_gy};
        raw     = (mag > MAG_MAX) ? '1 : mag[PIX_W-1:0];
        dop_raw = raw > T;
    end

    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        in_row_d    = in_row_q;
        in_col_d    = in_col_q;
        trig_row_d  = trig_row_q;
        trig_col_d  = trig_col_q;
        lb_col_d    = lb_col_q;
        flush_cnt_d = flush_cnt_q;
        left_col_d  = left_col_q;
        mid_col_d   = mid_col_q;
        s1_valid_d  = s1_valid_q;
        s1_win_d    = s1_win_q;
        s1_row_d    = s1_row_q;
        s1_col_d    = s1_col_q;
        s1_end_d    = s1_end_q;
        out_valid_d = out_valid_q;
        grad_d      = grad_q;
        dop_d       = dop_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_end_d   = out_end_q;

        if (slot) begin
            left_col_d = mid_col_q;
            mid_col_d  = '{lb1_rd, lb0_rd, pix_in};
            lb_col_d   = (lb_col_q == LB_LAST) ? '0 : lb_col_q + AW'(1);
        end
        if (accept) begin
            in_col_d = (in_col_q == LAST_COL) ? '0 : in_col_q + CNT_W'(1);
            if (in_col_q == LAST_COL)
                in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + CNT_W'(1);
        end
        if (flush_slot)
            flush_cnt_d = flush_cnt_q + FW'(1);
        if (trig) begin
            trig_col_d = (trig_col_q == LAST_COL) ? '0 : trig_col_q + CNT_W'(1);
            if (trig_col_q == LAST_COL)
                trig_row_d = (trig_row_q == LAST_ROW) ? '0 : trig_row_q + CNT_W'(1);
        end

        if (!stall) begin
            s1_valid_d = trig;
            if (trig) begin
                s1_win_d = win;
                s1_row_d = trig_row_q;
                s1_col_d = trig_col_q;
                s1_end_d = (trig_row_q == LAST_ROW) && (trig_col_q == LAST_COL);
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                grad_d    = BinaryMode ? {PIX_W{dop_raw}} : raw;
                dop_d     = dop_raw;
                out_row_d = s1_row_q;
                out_col_d = s1_col_q;
                out_end_d = s1_end_q;
            end
        end

        case (state_q)
            FILL:  if (accept && in_row_q == CNT_W'(1) && in_col_q == '0) state_d = RUN;
            RUN:   if (accept && in_row_q == LAST_ROW && in_col_q == LAST_COL) state_d = FLUSH;
            FLUSH: begin
                if (out_valid_q && OutReady && out_end_q) begin
                    state_d     = FILL;
                    in_row_d    = '0;
                    in_col_d    = '0;
                    trig_row_d  = '0;
                    trig_col_d  = '0;
                    lb_col_d    = '0;
                    flush_cnt_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= FILL;
            in_row_q    <= '0;
            in_col_q    <= '0;
            trig_row_q  <= '0;
            trig_col_q  <= '0;
            lb_col_q    <= '0;
            flush_cnt_q <= '0;
            left_col_q  <= '{default: '0};
            mid_col_q   <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_win_q    <= '{default: '0};
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s1_end_q    <= 1'b0;
            out_valid_q <= 1'b0;
            grad_q      <= '0;
            dop_q       <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_row_q    <= in_row_d;
            in_col_q    <= in_col_d;
            trig_row_q  <= trig_row_d;
            trig_col_q  <= trig_col_d;
            lb_col_q    <= lb_col_d;
            flush_cnt_q <= flush_cnt_d;
            left_col_q  <= left_col_d;
            mid_col_q   <= mid_col_d;
            s1_valid_q  <= s1_valid_d;
            s1_win_q    <= s1_win_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            s1_end_q    <= s1_end_d;
            out_valid_q <= out_valid_d;
            grad_q      <= grad_d;
            dop_q       <= dop_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_end_q   <= out_end_d;
        end
    end

    // NOTE: line buffers carry no reset; masking makes their contents irrelevant
    // until written, and leaving them unreset lets them map onto RAM.
    always_ff @(posedge Clk) begin
        if (slot) begin
            lb0_mem[lb_col_q] <= pix_in;
            lb1_mem[lb_col_q] <= lb0_rd;
        end
    end

    assign InReady    = in_ready;
    assign Gradient   = grad_q;
    assign Dop        = dop_q;
    assign OutValid   = out_valid_q;
    assign Out_Row    = out_row_q;
    assign Out_Column = out_col_q;
    assign isEnd      = out_end_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine on a 4x4 image: a reference Sobel
// model fills the expected queue, a negedge monitor pops on every output handshake.
module tb_sobel_stream_engine;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int CNT_W = 10;
    localparam int NPIX  = IMG_W * IMG_H;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [PIX_W-1:0] DataIn;
    logic             InValid;
    logic             InReady;
    logic [PIX_W-1:0] T;
    logic             BinaryMode;
    logic [PIX_W-1:0] Gradient;
    logic             Dop;
    logic             OutValid;
    logic             OutReady;
    logic [CNT_W-1:0] Out_Row;
    logic [CNT_W-1:0] Out_Column;
    logic             isEnd;

    sobel_stream_engine #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .InValid(InValid), .InReady(InReady),
        .T(T), .BinaryMode(BinaryMode), .Gradient(Gradient), .Dop(Dop),
        .OutValid(OutValid), .OutReady(OutReady), .Out_Row(Out_Row),
        .Out_Column(Out_Column), .isEnd(isEnd)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int grad;
        int dop;
        int row;
        int col;
        int is_end;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   pop_cnt = 0;
    bit   ignore_out = 1'b0;
    int   img [NPIX];
    int   cap_grad [NPIX];
    int   cap_dop [NPIX];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int px(input int r, input int c);
        if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 0;
        return img[r * IMG_W + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_frame(input int thr, input bit bin);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                int gx, gy, raw;
                exp_t e;
                gx = (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1))
                   - (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1));
                gy = (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1))
                   - (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1));
                raw = iabs(gx) + iabs(gy);
                if (raw > 255) raw = 255;
                e.dop    = (raw > thr) ? 1 : 0;
                e.grad   = bin ? (e.dop ? 255 : 0) : raw;
                e.row    = r;
                e.col    = c;
                e.is_end = (r == IMG_H - 1 && c == IMG_W - 1) ? 1 : 0;
                sb_q.push_back(e);
            end
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset && OutValid && OutReady && !ignore_out) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got row %0d col %0d, expected none", Out_Row, Out_Column);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("grad(%0d,%0d)", e.row, e.col), Gradient, e.grad);
                check($sformatf("dop(%0d,%0d)", e.row, e.col), Dop, e.dop);
                check($sformatf("row(%0d,%0d)", e.row, e.col), Out_Row, e.row);
                check($sformatf("col(%0d,%0d)", e.row, e.col), Out_Column, e.col);
                check($sformatf("isEnd(%0d,%0d)", e.row, e.col), isEnd, e.is_end);
                cap_grad[e.row * IMG_W + e.col] = Gradient;
                cap_dop[e.row * IMG_W + e.col]  = Dop;
                pop_cnt++;
            end
        end
    end

    // Inputs change just after a negedge; InReady is sampled 1 unit before the posedge.
    task automatic send_pixels(input int n);
        bit acc;
        int waited;
        @(negedge Clk);
        for (int i = 0; i < n; i++) begin
            DataIn  = PIX_W'(img[i]);
            InValid = 1'b1;
            acc     = 1'b0;
            waited  = 0;
            while (!acc && waited < 100) begin
                #4;
                acc = InReady;
                @(negedge Clk);
                waited++;
            end
            if (!acc) fail_now($sformatf("accept_pixel_%0d", i));
        end
        InValid = 1'b0;
    endtask

    task automatic wait_drain(input int base);
        int waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            @(negedge Clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            fail_now("drain_outputs");
            sb_q.delete();
        end
        check("frame_output_count", pop_cnt - base, NPIX);
    endtask

    task automatic run_frame(input int thr, input bit bin);
        int base;
        T          = PIX_W'(thr);
        BinaryMode = bin;
        base       = pop_cnt;
        push_frame(thr, bin);
        send_pixels(NPIX);
        wait_drain(base);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        Reset = 1'b1; DataIn = '0; InValid = 1'b0; T = '0; BinaryMode = 1'b0; OutReady = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset_outvalid", OutValid, 0);
        check("reset_gradient", Gradient, 0);
        check("reset_dop", Dop, 0);
        check("reset_row", Out_Row, 0);
        check("reset_col", Out_Column, 0);
        check("reset_isend", isEnd, 0);
        check("reset_inready", InReady, 1);
        Reset = 1'b0;

        // 1: all-zero frame
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        run_frame(0, 1'b0);

        // 2: constant 100, T=0
        for (int i = 0; i < NPIX; i++) img[i] = 100;
        run_frame(0, 1'b0);
        check("const_corner_grad", cap_grad[0], 255);
        check("const_corner_dop", cap_dop[0], 1);
        check("const_inner_grad", cap_grad[5], 0);
        check("const_inner_dop", cap_dop[5], 0);

        // 3: vertical step, cols 0-1 = 0, cols 2-3 = 255
        for (int i = 0; i < NPIX; i++) img[i] = (i % IMG_W >= 2) ? 255 : 0;
        run_frame(100, 1'b0);
        check("step_grad_1_1", cap_grad[5], 255);
        check("step_grad_1_2", cap_grad[6], 255);
        check("step_grad_1_0", cap_grad[4], 0);

        // 4: 5-cycle output stall mid-frame
        for (int i = 0; i < NPIX; i++) img[i] = (i * 37 + 11) % 256;
        T = 8'd60; BinaryMode = 1'b0;
        base = pop_cnt;
        push_frame(60, 1'b0);
        fork
            send_pixels(NPIX);
            begin
                int w = 0;
                while (pop_cnt < base + 3 && w < 200) begin
                    @(negedge Clk);
                    w++;
                end
                if (pop_cnt < base + 3) fail_now("stall_start");
                @(posedge Clk); #1;
                OutReady = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge Clk);
                    check("stall_outvalid", OutValid, 1);
                    check("stall_inready", InReady, 0);
                    if (sb_q.size() > 0) begin
                        check("stall_gradient", Gradient, sb_q[0].grad);
                        check("stall_row", Out_Row, sb_q[0].row);
                        check("stall_col", Out_Column, sb_q[0].col);
                    end
                end
                @(posedge Clk); #1;
                OutReady = 1'b1;
            end
        join
        wait_drain(base);

        // 5: binary map on the step pattern, T=200
        for (int i = 0; i < NPIX; i++) img[i] = (i % IMG_W >= 2) ? 255 : 0;
        run_frame(200, 1'b1);
        for (int i = 0; i < NPIX; i++)
            check($sformatf("binary_level_%0d", i), (cap_grad[i] == 0 || cap_grad[i] == 255) ? 1 : 0, 1);
        check("binary_grad_1_1", cap_grad[5], 255);
        check("binary_dop_1_1", cap_dop[5], 1);
        check("binary_grad_1_0", cap_grad[4], 0);
        check("binary_dop_1_0", cap_dop[4], 0);

        // 6: reset after 7 accepts, then a fresh frame
        for (int i = 0; i < NPIX; i++) img[i] = (i * 53 + 7) % 256;
        ignore_out = 1'b1;
        send_pixels(7);
        Reset = 1'b1;
        @(negedge Clk);
        check("midreset_outvalid", OutValid, 0);
        check("midreset_inready", InReady, 1);
        check("midreset_gradient", Gradient, 0);
        check("midreset_row", Out_Row, 0);
        Reset = 1'b0;
        sb_q.delete();
        ignore_out = 1'b0;
        run_frame(90, 1'b0);

        repeat (3) @(negedge Clk);
        check("idle_outvalid", OutValid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
